fetch_unit: RTL and testbench

- Instruction-fetch producer that drives the IF/ID pipeline buffer: owns the program counter, reads 16-bit instruction words from instruction memory, and presents pc/instr/in-port values for the buffer to capture.
- Loads a 32-bit reset vector from memory after reset, then fetches sequentially.
- Honours the downstream stall and branch/jump redirect signals (the same hazard sources that drive the buffer's stall/flush).

---
 rtl/fetch_unit.sv | 96 +++++++++
 tb/tb_fetch_unit.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch producer for the IF/ID buffer: boots the PC from a
// two-word reset vector, then fetches sequentially with stall and redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_VEC_ADDR = 32'h0,
  parameter logic [15:0] NOP_INSTR      = 16'h5000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic [15:0] in_port_in,
  output logic [31:0] pc_out,
  output logic [15:0] instr_out,
  output logic [15:0] in_port_out,
  output logic        valid_out,
  output logic        boot_done
);

  localparam int unsigned PC_W    = 32;
  localparam int unsigned INSTR_W = 16;

  typedef enum logic [1:0] {
    BOOT_HI = 2'd0,
    BOOT_LO = 2'd1,
    RUN     = 2'd2
  } state_t;

  state_t             state, state_next;
  logic [PC_W-1:0]    pc_reg, pc_next, pc_inc;
  logic [INSTR_W-1:0] vec_hi, vec_hi_next;
  logic               boot_done_next;

  // Sequential PC successor; carry out of bit 31 is dropped so 0xFFFF_FFFF wraps to 0.
  assign pc_inc = pc_reg + PC_W'(1);

  // State, PC, vector-high and boot flag registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= BOOT_HI;
      pc_reg    <= '0;
      vec_hi    <= '0;
      boot_done <= 1'b0;
    end else begin
      state     <= state_next;
      pc_reg    <= pc_next;
      vec_hi    <= vec_hi_next;
      boot_done <= boot_done_next;
    end
  end

  // Next-state, next-PC and combinational fetch outputs.
  always_comb begin
    state_next     = state;
    pc_next        = pc_reg;
    vec_hi_next    = vec_hi;
    boot_done_next = boot_done;
    imem_addr      = RESET_VEC_ADDR;
    pc_out         = '0;
    instr_out      = NOP_INSTR;
    in_port_out    = '0;
    valid_out      = 1'b0;

    case (state)
      BOOT_HI: begin
        vec_hi_next = imem_data;
        state_next  = BOOT_LO;
      end
      BOOT_LO: begin
        imem_addr      = RESET_VEC_ADDR + PC_W'(1);
        pc_next        = {vec_hi, imem_data};
        boot_done_next = 1'b1;
        state_next     = RUN;
      end
      RUN: begin
        imem_addr   = pc_reg;
        pc_out      = pc_inc;
        instr_out   = imem_data;
        in_port_out = in_port_in;
        valid_out   = 1'b1;
        // Redirect wins over stall; the wrong-path word is flushed downstream.
        if (redirect) begin
          pc_next = redirect_pc;
        end else if (!stall) begin
          pc_next = pc_inc;
        end
      end
      default: begin
        state_next = BOOT_HI;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus pushes expected outputs per
// cycle, a negedge monitor pops and compares against the DUT.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, stall, redirect;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [15:0] imem_data;
  logic [15:0] in_port_in;
  logic [31:0] pc_out;
  logic [15:0] instr_out;
  logic [15:0] in_port_out;
  logic        valid_out;
  logic        boot_done;

  logic [15:0] mem [0:511];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] pc;
    logic [15:0] instr;
    logic [15:0] inp;
    logic        valid;
    logic        bd;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc_no = 0;

  always #5 clk = ~clk;

  // Combinational instruction memory, aliased on the low 9 address bits.
  assign imem_data = mem[imem_addr[8:0]];

  fetch_unit #(
    .RESET_VEC_ADDR(32'h0),
    .NOP_INSTR     (16'h5000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .in_port_in (in_port_in),
    .pc_out     (pc_out),
    .instr_out  (instr_out),
    .in_port_out(in_port_out),
    .valid_out  (valid_out),
    .boot_done  (boot_done)
  );

  task automatic chk32(input string name, input int c, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, c, act, req);
    end
  endtask

  // Monitor: pop one expectation per cycle and compare mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk32("imem_addr",   e.cyc, imem_addr,            e.addr);
      chk32("pc_out",      e.cyc, pc_out,               e.pc);
      chk32("instr_out",   e.cyc, {16'h0, instr_out},   {16'h0, e.instr});
      chk32("in_port_out", e.cyc, {16'h0, in_port_out}, {16'h0, e.inp});
      chk32("valid_out",   e.cyc, {31'h0, valid_out},   {31'h0, e.valid});
      chk32("boot_done",   e.cyc, {31'h0, boot_done},   {31'h0, e.bd});
    end
  end

  // Drive one cycle of inputs; optionally queue the outputs expected during it.
  task automatic step(input logic r, input logic s, input logic rd, input logic [31:0] rpc,
                      input logic chk, input logic [31:0] ea, input logic [31:0] epc,
                      input logic [15:0] ei, input logic ev, input logic ebd);
    exp_t e;
    logic [15:0] inval;
    cyc_no++;
    inval       = 16'h1000 + 16'(cyc_no);
    rst         = r;
    stall       = s;
    redirect    = rd;
    redirect_pc = rpc;
    in_port_in  = inval;
    if (chk) begin
      e.addr  = ea;
      e.pc    = epc;
      e.instr = ei;
      e.inp   = ev ? inval : 16'h0;
      e.valid = ev;
      e.bd    = ebd;
      e.cyc   = cyc_no;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 16'h0BAD;
    mem[9'h000] = 16'h0000;
    mem[9'h001] = 16'h0020;
    mem[9'h020] = 16'hA001;
    mem[9'h021] = 16'hA002;
    mem[9'h022] = 16'hA003;
    mem[9'h023] = 16'hA004;
    mem[9'h030] = 16'hB030;
    mem[9'h100] = 16'hC100;
    mem[9'h1FF] = 16'hD1FF;
    mem[9'h045] = 16'hE045;
    mem[9'h050] = 16'hF050;
    mem[9'h051] = 16'hF051;
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; in_port_in = '0;

    //   rst   stl   rd    rpc           chk   addr          pc_out        instr     v     bd
    step(1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0,        16'h0,    1'b0, 1'b0);
    // Boot with stall/redirect asserted: both must be ignored.
    step(1'b0, 1'b1, 1'b1, 32'h300,      1'b1, 32'h0,        32'h0,        16'h5000, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h300,      1'b1, 32'h1,        32'h0,        16'h5000, 1'b0, 1'b0);
    // Sequential fetch from vector 0x20.
    step(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h20,       32'h21,       16'hA001, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h21,       32'h22,       16'hA002, 1'b1, 1'b1);
    // Three stall cycles at 0x22.
    step(1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h22,       32'h23,       16'hA003, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h22,       32'h23,       16'hA003, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h22,       32'h23,       16'hA003, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h22,       32'h23,       16'hA003, 1'b1, 1'b1);
    // Advance, then redirect to 0x30.
    step(1'b0, 1'b0, 1'b1, 32'h30,       1'b1, 32'h23,       32'h24,       16'hA004, 1'b1, 1'b1);
    // Redirect with simultaneous stall to 0x100.
    step(1'b0, 1'b1, 1'b1, 32'h100,      1'b1, 32'h30,       32'h31,       16'hB030, 1'b1, 1'b1);
    // Redirect to the top of the address space.
    step(1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b1, 32'h100,      32'h101,      16'hC100, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'hFFFFFFFF, 32'h0,        16'hD1FF, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0,        32'h1,        16'h0000, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 32'h45,       1'b1, 32'h1,        32'h2,        16'h0020, 1'b1, 1'b1);
    // Reset at 0x45 with redirect also high; change the vector to 0x0001_0050.
    mem[9'h000] = 16'h0001;
    mem[9'h001] = 16'h0050;
    step(1'b1, 1'b0, 1'b1, 32'h77,       1'b1, 32'h45,       32'h46,       16'hE045, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0,        32'h0,        16'h5000, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h1,        32'h0,        16'h5000, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h10050,    32'h10051,    16'hF050, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h10051,    32'h10052,    16'hF051, 1'b1, 1'b1);
    // Reset mid-RUN, then again during BOOT_LO.
    step(1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h10051,    32'h10052,    16'hF051, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0,        32'h0,        16'h5000, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h1,        32'h0,        16'h5000, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0,        32'h0,        16'h5000, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h1,        32'h0,        16'h5000, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h10050,    32'h10051,    16'hF050, 1'b1, 1'b1);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
